tlb_entry_file: RTL and testbench
=================================

Name: tlb_entry_file

Overview:
- Joint TLB storage and lookup array for the MIPS core.
- Receives the write-back stage's TLBWI write port and returns the read-port fields that CP0 latches on TLBR.
- Provides two search ports:
  - port 0 for fetch translation;
  - port 1 for execute-stage load/store translation and the TLBP probe.
- Entries are held in flops, with a per-entry "exists" bit so that never-written entries cannot hit.

Parameters:
TLBNUM, 16, number of entries; must be a power of two, 2..64
IDXW, 4, index width; must equal log2(TLBNUM)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s0_vpn2  in  19  port0 virtual page pair number (VA[31:13])
s0_odd_page  in  1  port0 VA[12]
s0_asid  in  8  port0 ASID
s0_found  out  1  port0 hit
s0_index  out  IDXW  port0 hit index
s0_pfn  out  20  port0 selected PFN
s0_c  out  3  port0 cache attribute
s0_d  out  1  port0 dirty
s0_v  out  1  port0 valid
s1_vpn2 / s1_odd_page / s1_asid / s1_found / s1_index / s1_pfn / s1_c / s1_d / s1_v, same directions and widths as port0, second search port
we  in  1  write enable (TLBWI commit)
w_index  in  IDXW  write index
w_vpn2  in  19  write VPN2
w_asid  in  8  write ASID
w_g  in  1  write global bit
w_pfn0  in  20  even-page PFN
w_c0  in  3  even-page cache attribute
w_d0  in  1  even-page dirty bit
w_v0  in  1  even-page valid bit
w_pfn1  in  20  odd-page PFN
w_c1  in  3  odd-page cache attribute
w_d1  in  1  odd-page dirty bit
w_v1  in  1  odd-page valid bit
r_index  in  IDXW  read index
r_vpn2  out  19  read VPN2 of entry r_index
r_asid  out  8  read ASID
r_g  out  1  read global bit
r_pfn0  out  20  read even-page PFN
r_c0  out  3  read even-page cache attribute
r_d0  out  1  read even-page dirty bit
r_v0  out  1  read even-page valid bit
r_pfn1  out  20  read odd-page PFN
r_c1  out  3  read odd-page cache attribute
r_d1  out  1  read odd-page dirty bit
r_v1  out  1  read odd-page valid bit

Behaviour:
- Storage: per entry, fields vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1, plus an exists bit e.
- Reset: all fields and all e bits go to 0.
  - Post-reset outputs: s*_found=0, s*_index=0, s*_pfn=0, s*_c=0, s*_d=0, s*_v=0, all r_* = 0.
- Write:
  - At the posedge where we=1, entry[w_index] takes all w_* fields and sets e=1. One-cycle write latency.
  - w_index beyond TLBNUM-1 cannot occur, since IDXW equals log2(TLBNUM).
  - reset=1 has priority over we in the same cycle; that write is discarded.
- Match for entry i on port n:
  - e[i]=1, vpn2[i]==sn_vpn2, and (g[i]==1 or asid[i]==sn_asid).
- Search outputs, combinational in the base build:
  - found = OR of all match bits.
  - index = lowest matching i when more than one entry matches; 0 when no entry matches.
  - When sn_odd_page=1, pfn/c/d/v come from bank 1 of the winning entry; otherwise from bank 0.
  - On a miss, pfn/c/d/v are all 0.
- Write/search collision: a search in the same cycle as a write to the matching entry returns the pre-write contents. The new contents are visible from the next cycle.
- Read port: combinational from entry[r_index].
  - Returns stored fields regardless of e; a never-written entry reads all zeros.
  - Read and write to the same index in the same cycle returns the old value.
- Port independence: ports 0 and 1 are fully independent and may hit the same entry in the same cycle.

Optional Feature:
- Macro: TLB_SEARCH_REG_EN.
- Defined:
  - All s0_*/s1_* outputs are registered, giving 1-cycle search latency. The result at cycle t+1 reflects the inputs and array contents at cycle t.
  - A write at edge t is not visible to a search issued at t; it is visible to a search issued at t+1, whose result appears at t+2.
  - The output registers reset to 0.
- Undefined: search outputs are purely combinational, as described in Behaviour.

Test Plan:
- Reset, then search s0 with vpn2=0, asid=0 -> s0_found=0, s0_index=0, s0_pfn=0, despite zeroed fields.
- Write index 3: vpn2=19'h12345, asid=8'h0A, g=0, pfn0=20'hABCDE, v0=1, c0=3, d0=1, pfn1=20'h11111, v1=0. Next cycle:
  - s1 search (vpn2 12345, odd 0, asid 0A) -> found=1, index=3, pfn=ABCDE, c=3, d=1, v=1.
  - Same search with odd 1 -> pfn=11111, v=0.
- Same entry with asid 0B -> miss. Rewrite index 3 with g=1 -> a search with asid 0B hits index 3.
- Write identical vpn2/asid into indexes 9 and 5 -> search returns index=5.
  - In the same cycle that a write to index 3 changes its vpn2, a search for the old vpn2 -> still hits 3. The next cycle -> miss.
- r_index=3 after the writes above -> r_* equal the last written fields. r_index=7, never written -> all zeros.
- With TLB_SEARCH_REG_EN: issue a hit search at cycle t -> s0_found=0 at t, s0_found=1 with correct index at t+1. reset asserted at t+1 -> outputs 0 at t+2.

Source files
------------

// File: rtl/tlb_entry_file_if.sv
// Bus bundle for tlb_entry_file: two search ports, the TLBWI write port and the TLBR read port.
interface tlb_entry_file_if #(
    parameter int unsigned IDXW = 4
);
    logic [18:0]     s0_vpn2;
    logic            s0_odd_page;
    logic [7:0]      s0_asid;
    logic            s0_found;
    logic [IDXW-1:0] s0_index;
    logic [19:0]     s0_pfn;
    logic [2:0]      s0_c;
    logic            s0_d;
    logic            s0_v;

    logic [18:0]     s1_vpn2;
    logic            s1_odd_page;
    logic [7:0]      s1_asid;
    logic            s1_found;
    logic [IDXW-1:0] s1_index;
    logic [19:0]     s1_pfn;
    logic [2:0]      s1_c;
    logic            s1_d;
    logic            s1_v;

    logic            we;
    logic [IDXW-1:0] w_index;
    logic [18:0]     w_vpn2;
    logic [7:0]      w_asid;
    logic            w_g;
    logic [19:0]     w_pfn0;
    logic [2:0]      w_c0;
    logic            w_d0;
    logic            w_v0;
    logic [19:0]     w_pfn1;
    logic [2:0]      w_c1;
    logic            w_d1;
    logic            w_v1;

    logic [IDXW-1:0] r_index;
    logic [18:0]     r_vpn2;
    logic [7:0]      r_asid;
    logic            r_g;
    logic [19:0]     r_pfn0;
    logic [2:0]      r_c0;
    logic            r_d0;
    logic            r_v0;
    logic [19:0]     r_pfn1;
    logic [2:0]      r_c1;
    logic            r_d1;
    logic            r_v1;

    modport slave (
        input  s0_vpn2, s0_odd_page, s0_asid,
        output s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        input  s1_vpn2, s1_odd_page, s1_asid,
        output s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        input  we, w_index, w_vpn2, w_asid, w_g,
        input  w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
        input  r_index,
        output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
    );

    modport master (
        output s0_vpn2, s0_odd_page, s0_asid,
        input  s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
        output s1_vpn2, s1_odd_page, s1_asid,
        input  s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
        output we, w_index, w_vpn2, w_asid, w_g,
        output w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
        output r_index,
        input  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
    );
endinterface

// File: rtl/tlb_entry_file.sv
// Joint TLB entry array: flop storage, TLBWI write, TLBR read, two search ports.
// Optional macro TLB_SEARCH_REG_EN registers all search outputs (1-cycle search latency).
module tlb_entry_file #(
    parameter int unsigned TLBNUM = 16,
    parameter int unsigned IDXW   = 4
) (
    input  logic            clk,
    input  logic            reset,
    tlb_entry_file_if.slave bus
);
    localparam int unsigned NPORT = 2;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } entry_t;

    entry_t            r_ent [TLBNUM];
    logic [TLBNUM-1:0] r_e;

    logic [18:0]     w_s_vpn2  [NPORT];
    logic            w_s_odd   [NPORT];
    logic [7:0]      w_s_asid  [NPORT];
    logic            w_found   [NPORT];
    logic [IDXW-1:0] w_index   [NPORT];
    logic [19:0]     w_pfn     [NPORT];
    logic [2:0]      w_c       [NPORT];
    logic            w_d       [NPORT];
    logic            w_v       [NPORT];

    assign w_s_vpn2[0] = bus.s0_vpn2;
    assign w_s_odd[0]  = bus.s0_odd_page;
    assign w_s_asid[0] = bus.s0_asid;
    assign w_s_vpn2[1] = bus.s1_vpn2;
    assign w_s_odd[1]  = bus.s1_odd_page;
    assign w_s_asid[1] = bus.s1_asid;

    // Entry storage: reset clears everything and wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(TLBNUM); i++) begin
                r_ent[i] <= '0;
            end
            r_e <= '0;
        end else if (bus.we) begin
            r_ent[bus.w_index] <= '{vpn2: bus.w_vpn2, asid: bus.w_asid, g: bus.w_g,
                                   pfn0: bus.w_pfn0, c0: bus.w_c0, d0: bus.w_d0, v0: bus.w_v0,
                                   pfn1: bus.w_pfn1, c1: bus.w_c1, d1: bus.w_d1, v1: bus.w_v1};
            r_e[bus.w_index]   <= 1'b1;
        end
    end

    // Search: scan high to low so the lowest matching index wins; a miss returns zeros.
    always_comb begin
        for (int p = 0; p < int'(NPORT); p++) begin
            w_found[p] = 1'b0;
            w_index[p] = '0;
            w_pfn[p]   = '0;
            w_c[p]     = '0;
            w_d[p]     = 1'b0;
            w_v[p]     = 1'b0;
            for (int i = int'(TLBNUM) - 1; i >= 0; i--) begin
                if (r_e[i] && (r_ent[i].vpn2 == w_s_vpn2[p]) &&
                    (r_ent[i].g || (r_ent[i].asid == w_s_asid[p]))) begin
                    w_found[p] = 1'b1;
                    w_index[p] = IDXW'(i);
                    w_pfn[p]   = w_s_odd[p] ? r_ent[i].pfn1 : r_ent[i].pfn0;
                    w_c[p]     = w_s_odd[p] ? r_ent[i].c1   : r_ent[i].c0;
                    w_d[p]     = w_s_odd[p] ? r_ent[i].d1   : r_ent[i].d0;
                    w_v[p]     = w_s_odd[p] ? r_ent[i].v1   : r_ent[i].v0;
                end
            end
        end
    end

`ifdef TLB_SEARCH_REG_EN
    logic            r_s_found [NPORT];
    logic [IDXW-1:0] r_s_index [NPORT];
    logic [19:0]     r_s_pfn   [NPORT];
    logic [2:0]      r_s_c     [NPORT];
    logic            r_s_d     [NPORT];
    logic            r_s_v     [NPORT];

    // Search result registers: sample pre-write array contents at each edge.
    always_ff @(posedge clk) begin
        for (int p = 0; p < int'(NPORT); p++) begin
            if (reset) begin
                r_s_found[p] <= 1'b0;
                r_s_index[p] <= '0;
                r_s_pfn[p]   <= '0;
                r_s_c[p]     <= '0;
                r_s_d[p]     <= 1'b0;
                r_s_v[p]     <= 1'b0;
            end else begin
                r_s_found[p] <= w_found[p];
                r_s_index[p] <= w_index[p];
                r_s_pfn[p]   <= w_pfn[p];
                r_s_c[p]     <= w_c[p];
                r_s_d[p]     <= w_d[p];
                r_s_v[p]     <= w_v[p];
            end
        end
    end

    assign bus.s0_found = r_s_found[0];
    assign bus.s0_index = r_s_index[0];
    assign bus.s0_pfn   = r_s_pfn[0];
    assign bus.s0_c     = r_s_c[0];
    assign bus.s0_d     = r_s_d[0];
    assign bus.s0_v     = r_s_v[0];
    assign bus.s1_found = r_s_found[1];
    assign bus.s1_index = r_s_index[1];
    assign bus.s1_pfn   = r_s_pfn[1];
    assign bus.s1_c     = r_s_c[1];
    assign bus.s1_d     = r_s_d[1];
    assign bus.s1_v     = r_s_v[1];
`else
    assign bus.s0_found = w_found[0];
    assign bus.s0_index = w_index[0];
    assign bus.s0_pfn   = w_pfn[0];
    assign bus.s0_c     = w_c[0];
    assign bus.s0_d     = w_d[0];
    assign bus.s0_v     = w_v[0];
    assign bus.s1_found = w_found[1];
    assign bus.s1_index = w_index[1];
    assign bus.s1_pfn   = w_pfn[1];
    assign bus.s1_c     = w_c[1];
    assign bus.s1_d     = w_d[1];
    assign bus.s1_v     = w_v[1];
`endif

    // TLBR read port: raw stored fields, independent of the exists bit.
    assign bus.r_vpn2 = r_ent[bus.r_index].vpn2;
    assign bus.r_asid = r_ent[bus.r_index].asid;
    assign bus.r_g    = r_ent[bus.r_index].g;
    assign bus.r_pfn0 = r_ent[bus.r_index].pfn0;
    assign bus.r_c0   = r_ent[bus.r_index].c0;
    assign bus.r_d0   = r_ent[bus.r_index].d0;
    assign bus.r_v0   = r_ent[bus.r_index].v0;
    assign bus.r_pfn1 = r_ent[bus.r_index].pfn1;
    assign bus.r_c1   = r_ent[bus.r_index].c1;
    assign bus.r_d1   = r_ent[bus.r_index].d1;
    assign bus.r_v1   = r_ent[bus.r_index].v1;
endmodule

// File: tb/tb_tlb_entry_file.sv
// Directed self-checking bench for tlb_entry_file; search results go through a scoreboard queue.
module tb_tlb_entry_file;
    logic clk;
    logic reset;

    tlb_entry_file_if #(.IDXW(4)) bus ();

    tlb_entry_file #(.TLBNUM(16), .IDXW(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [29:0] exp;
        string       tag;
    } sb_t;

    sb_t q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    // Single comparison point.
    task automatic cmp(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Queue the expected {found,index,pfn,c,d,v} for a search port.
    task automatic expect_s(input int port, input string tag, input logic found, input logic [3:0] idx,
                            input logic [19:0] pfn, input logic [2:0] c, input logic d, input logic v);
        sb_t e;
        e.port = port;
        e.exp  = {found, idx, pfn, c, d, v};
        e.tag  = tag;
        q.push_back(e);
    endtask

    task automatic drive_s(input int port, input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
        if (port == 0) begin
            bus.s0_vpn2 = vpn2; bus.s0_odd_page = odd; bus.s0_asid = asid;
        end else begin
            bus.s1_vpn2 = vpn2; bus.s1_odd_page = odd; bus.s1_asid = asid;
        end
    endtask

    task automatic drain();
        sb_t         e;
        logic [29:0] obs;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.port == 0)
                obs = {bus.s0_found, bus.s0_index, bus.s0_pfn, bus.s0_c, bus.s0_d, bus.s0_v};
            else
                obs = {bus.s1_found, bus.s1_index, bus.s1_pfn, bus.s1_c, bus.s1_d, bus.s1_v};
            cmp(e.tag, 96'(obs), 96'(e.exp));
        end
    endtask

    // One cycle: inputs were driven after a negedge; compare where the result is due; end at next negedge.
    task automatic tick();
`ifdef TLB_SEARCH_REG_EN
        @(posedge clk);
        #1;
        drain();
        @(negedge clk);
`else
        #1;
        drain();
        @(posedge clk);
        @(negedge clk);
`endif
    endtask

    task automatic write_ent(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                             input logic g, input logic [19:0] pfn0, input logic [2:0] c0,
                             input logic d0, input logic v0, input logic [19:0] pfn1,
                             input logic [2:0] c1, input logic d1, input logic v1);
        bus.we = 1'b1; bus.w_index = idx; bus.w_vpn2 = vpn2; bus.w_asid = asid; bus.w_g = g;
        bus.w_pfn0 = pfn0; bus.w_c0 = c0; bus.w_d0 = d0; bus.w_v0 = v0;
        bus.w_pfn1 = pfn1; bus.w_c1 = c1; bus.w_d1 = d1; bus.w_v1 = v1;
    endtask

    task automatic check_read(input string tag, input logic [3:0] idx, input logic [77:0] exp);
        logic [77:0] obs;
        bus.r_index = idx;
        #1;
        obs = {bus.r_vpn2, bus.r_asid, bus.r_g, bus.r_pfn0, bus.r_c0, bus.r_d0, bus.r_v0,
               bus.r_pfn1, bus.r_c1, bus.r_d1, bus.r_v1};
        cmp(tag, 96'(obs), 96'(exp));
    endtask

    initial begin
        reset = 1'b1;
        bus.we = 1'b0; bus.w_index = '0; bus.w_vpn2 = '0; bus.w_asid = '0; bus.w_g = 1'b0;
        bus.w_pfn0 = '0; bus.w_c0 = '0; bus.w_d0 = 1'b0; bus.w_v0 = 1'b0;
        bus.w_pfn1 = '0; bus.w_c1 = '0; bus.w_d1 = 1'b0; bus.w_v1 = 1'b0;
        bus.r_index = '0;
        drive_s(0, 19'h0, 1'b0, 8'h00);
        drive_s(1, 19'h0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Zeroed but never-written entries must not hit.
        expect_s(0, "rst_s0", 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        expect_s(1, "rst_s1", 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        tick();
        check_read("rst_r0", 4'd0, 78'h0);

        write_ent(4'd3, 19'h12345, 8'h0A, 1'b0, 20'hABCDE, 3'd3, 1'b1, 1'b1, 20'h11111, 3'd0, 1'b0, 1'b0);
        tick();
        bus.we = 1'b0;

        drive_s(1, 19'h12345, 1'b0, 8'h0A);
        drive_s(0, 19'h12345, 1'b1, 8'h0A);
        expect_s(1, "hit3_even", 1'b1, 4'd3, 20'hABCDE, 3'd3, 1'b1, 1'b1);
        expect_s(0, "hit3_odd",  1'b1, 4'd3, 20'h11111, 3'd0, 1'b0, 1'b0);
        tick();

        drive_s(0, 19'h12345, 1'b0, 8'h0B);
        expect_s(0, "asid_miss", 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        tick();

        write_ent(4'd3, 19'h12345, 8'h0A, 1'b1, 20'hABCDE, 3'd3, 1'b1, 1'b1, 20'h11111, 3'd0, 1'b0, 1'b0);
        tick();
        bus.we = 1'b0;
        expect_s(0, "global_hit", 1'b1, 4'd3, 20'hABCDE, 3'd3, 1'b1, 1'b1);
        tick();

        // Duplicate tags in 9 and 5: lowest index wins on both ports.
        write_ent(4'd9, 19'h2AAAA, 8'h20, 1'b0, 20'h99999, 3'd2, 1'b0, 1'b1, 20'h99990, 3'd1, 1'b1, 1'b0);
        tick();
        write_ent(4'd5, 19'h2AAAA, 8'h20, 1'b0, 20'h55555, 3'd5, 1'b1, 1'b1, 20'h55550, 3'd4, 1'b0, 1'b1);
        tick();
        bus.we = 1'b0;
        drive_s(0, 19'h2AAAA, 1'b1, 8'h20);
        drive_s(1, 19'h2AAAA, 1'b0, 8'h20);
        expect_s(0, "dup_s0", 1'b1, 4'd5, 20'h55550, 3'd4, 1'b0, 1'b1);
        expect_s(1, "dup_s1", 1'b1, 4'd5, 20'h55555, 3'd5, 1'b1, 1'b1);
        tick();

        // Same-cycle write/search/read of entry 3 sees the old contents.
        write_ent(4'd3, 19'h00777, 8'h0A, 1'b1, 20'h33333, 3'd1, 1'b0, 1'b1, 20'h44444, 3'd6, 1'b1, 1'b1);
        drive_s(0, 19'h12345, 1'b0, 8'h0A);
        check_read("rd_during_wr", 4'd3,
                   {19'h12345, 8'h0A, 1'b1, 20'hABCDE, 3'd3, 1'b1, 1'b1, 20'h11111, 3'd0, 1'b0, 1'b0});
        expect_s(0, "coll_old", 1'b1, 4'd3, 20'hABCDE, 3'd3, 1'b1, 1'b1);
        tick();
        bus.we = 1'b0;
        drive_s(1, 19'h00777, 1'b1, 8'hFF);
        expect_s(0, "coll_after", 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        expect_s(1, "new_tag",    1'b1, 4'd3, 20'h44444, 3'd6, 1'b1, 1'b1);
        tick();

        check_read("rd3", 4'd3,
                   {19'h00777, 8'h0A, 1'b1, 20'h33333, 3'd1, 1'b0, 1'b1, 20'h44444, 3'd6, 1'b1, 1'b1});
        check_read("rd7_unwritten", 4'd7, 78'h0);
        check_read("rd9", 4'd9,
                   {19'h2AAAA, 8'h20, 1'b0, 20'h99999, 3'd2, 1'b0, 1'b1, 20'h99990, 3'd1, 1'b1, 1'b0});

        // Top index.
        write_ent(4'd15, 19'h7FFFF, 8'hFF, 1'b0, 20'hFFFFF, 3'd7, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
        tick();
        bus.we = 1'b0;
        drive_s(1, 19'h7FFFF, 1'b0, 8'hFF);
        expect_s(1, "hit15", 1'b1, 4'd15, 20'hFFFFF, 3'd7, 1'b1, 1'b1);
        tick();

`ifdef TLB_SEARCH_REG_EN
        // Latency: result not visible in the issuing cycle; reset clears output registers.
        drive_s(0, 19'h2AAAA, 1'b0, 8'h20);
        #1;
        cmp("reg_lat_t0", 96'(bus.s0_found), 96'(1'b0));
        expect_s(0, "reg_lat_t1", 1'b1, 4'd5, 20'h55555, 3'd5, 1'b1, 1'b1);
        tick();
        reset = 1'b1;
        expect_s(0, "reg_rst", 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
`endif

        // Reset beats a same-cycle write.
        reset = 1'b1;
        write_ent(4'd7, 19'h01234, 8'h01, 1'b1, 20'h77777, 3'd7, 1'b1, 1'b1, 20'h77777, 3'd7, 1'b1, 1'b1);
        tick();
        reset = 1'b0;
        bus.we = 1'b0;
        drive_s(0, 19'h01234, 1'b0, 8'h01);
        drive_s(1, 19'h2AAAA, 1'b0, 8'h20);
        expect_s(0, "rst_wins", 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        expect_s(1, "rst_clear", 1'b0, 4'd0, 20'h0, 3'd0, 1'b0, 1'b0);
        tick();
        check_read("rd7_after_rst", 4'd7, 78'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
